// File: rtl/la_prbs_pkg.sv
// ---------------------------------------------------------------------------
// la_prbs_pkg
// Shared definitions for the XNOR-feedback PRBS generator and checker:
//   - tap positions for each supported PRBS order (7, 15, 23, 31)
//   - checker state encoding (HUNT=0, CHECK=1, LOCKED=2)
//   - lockup-state mask (all ones across ORDER bits)
//   - popcount helper used when bit-error counting is enabled
// ---------------------------------------------------------------------------
package la_prbs_pkg;

    localparam int unsigned PRBS7_T1  = 32'd7;
    localparam int unsigned PRBS7_T2  = 32'd6;
    localparam int unsigned PRBS15_T1 = 32'd15;
    localparam int unsigned PRBS15_T2 = 32'd14;
    localparam int unsigned PRBS23_T1 = 32'd23;
    localparam int unsigned PRBS23_T2 = 32'd18;
    localparam int unsigned PRBS31_T1 = 32'd31;
    localparam int unsigned PRBS31_T2 = 32'd28;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_e;

    // First feedback tap (1-based bit position) for a given order.
    function automatic int unsigned prbs_tap1(input int unsigned order);
        case (order)
            32'd7:   return PRBS7_T1;
            32'd15:  return PRBS15_T1;
            32'd23:  return PRBS23_T1;
            32'd31:  return PRBS31_T1;
            default: return PRBS7_T1;
        endcase
    endfunction

    // Second feedback tap (1-based bit position) for a given order.
    function automatic int unsigned prbs_tap2(input int unsigned order);
        case (order)
            32'd7:   return PRBS7_T2;
            32'd15:  return PRBS15_T2;
            32'd23:  return PRBS23_T2;
            32'd31:  return PRBS31_T2;
            default: return PRBS7_T2;
        endcase
    endfunction

    // XNOR feedback can never leave the all-ones state; this is its pattern.
    function automatic logic [31:0] prbs_lockup_mask(input int unsigned order);
        logic [31:0] m;
        m = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i < order);
        end
        return m;
    endfunction

    // Number of set bits in a word of up to 64 bits.
    function automatic logic [6:0] prbs_popcount(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/la_prbs_step.sv
// ---------------------------------------------------------------------------
// la_prbs_step
// Combinational DW-bit unroll of the checker LFSR. For each received bit
// (bit 0 first) the feedback value is the prediction; the LFSR then shifts
// in the received bit rather than the prediction, so the local register
// self-synchronises to the incoming stream.
// Ports:
//   i_state    [ORDER-1:0]  LFSR state before the word
//   i_data     [DW-1:0]     received bits, bit 0 earliest
//   o_state    [ORDER-1:0]  LFSR state after the word
//   o_mismatch [DW-1:0]     per-bit received ^ predicted
// ---------------------------------------------------------------------------
module la_prbs_step
    import la_prbs_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ORDER = 7
) (
    input  logic [ORDER-1:0] i_state,
    input  logic [DW-1:0]    i_data,
    output logic [ORDER-1:0] o_state,
    output logic [DW-1:0]    o_mismatch
);

    localparam int T1 = int'(prbs_tap1(ORDER));
    localparam int T2 = int'(prbs_tap2(ORDER));

    logic [ORDER-1:0] w_s;
    logic             w_p;

    // Serial bit-by-bit prediction and shift, unrolled across the word.
    always_comb begin
        w_s        = i_state;
        w_p        = 1'b0;
        o_mismatch = '0;
        for (int i = 0; i < DW; i++) begin
            w_p           = ~(w_s[T1-1] ^ w_s[T2-1]);
            o_mismatch[i] = i_data[i] ^ w_p;
            w_s           = {w_s[ORDER-2:0], i_data[i]};
        end
        o_state = w_s;
    end

endmodule

// File: rtl/la_prbs_check.sv
// ---------------------------------------------------------------------------
// la_prbs_check
// Receive-side PRBS checker. Self-synchronises an XNOR LFSR from the received
// stream, declares lock after LOCK_CNT clean words, counts errored words
// (or bit errors when LA_PRBS_CHECK_BITERR_EN is defined) with saturation,
// and drops lock after LOSS_CNT consecutive errored words.
// Optional feature macro: LA_PRBS_CHECK_BITERR_EN (err_cnt adds popcount of
// the mismatch vector instead of 1 per errored word).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         checker enable; low forces HUNT and drops lock
//   valid_in   data_in carries a word this cycle
//   data_in    [DW-1:0] received bits, bit 0 earliest
//   clr_cnt    synchronous clear of err_cnt (wins over an increment)
//   locked     lock indicator (registered)
//   err_valid  one-cycle pulse after a checked word with any mismatch
//   err_cnt    [CW-1:0] saturating error count
// ---------------------------------------------------------------------------
module la_prbs_check
    import la_prbs_pkg::*;
#(
    parameter     PROP     = "DEFAULT",
    parameter int DW       = 8,
    parameter int ORDER    = 7,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 4,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    input  logic          clr_cnt,
    output logic          locked,
    output logic          err_valid,
    output logic [CW-1:0] err_cnt
);

    localparam int BCW = $clog2(ORDER + DW + 1);
    localparam int GCW = $clog2(LOCK_CNT + 1);
    localparam int LCW = $clog2(LOSS_CNT + 1);
    localparam int SW  = CW + 7;
    localparam logic [31:0]   LOCKUP_MASK = prbs_lockup_mask(ORDER);
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

    if (!((ORDER == 7) || (ORDER == 15) || (ORDER == 23) || (ORDER == 31)) ||
        (DW < 1) || (DW > 64)) begin : g_bad_cfg
        $error("la_prbs_check(%s): ORDER must be 7/15/23/31 and DW 1..64", PROP);
    end

    prbs_state_e      r_state,     w_state_nxt;
    logic [ORDER-1:0] r_lfsr,      w_lfsr_nxt;
    logic [BCW-1:0]   r_bit_cnt,   w_bit_cnt_nxt;
    logic [GCW-1:0]   r_good_cnt,  w_good_nxt;
    logic [LCW-1:0]   r_bad_cnt,   w_bad_nxt;
    logic             r_locked,    w_locked_nxt;
    logic             r_err_valid, w_err_valid_nxt;
    logic [CW-1:0]    r_err_cnt,   w_err_cnt_nxt;

    logic [ORDER-1:0] w_step_state;
    logic [DW-1:0]    w_mismatch;
    logic             w_word_err;
    logic             w_lockup;
    logic [BCW-1:0]   w_bit_sum;
    logic [6:0]       w_inc;
    logic [SW-1:0]    w_err_sum;
    logic [CW-1:0]    w_err_sat;

    la_prbs_step #(
        .DW    (DW),
        .ORDER (ORDER)
    ) u_step (
        .i_state    (r_lfsr),
        .i_data     (data_in),
        .o_state    (w_step_state),
        .o_mismatch (w_mismatch)
    );

    assign w_word_err = |w_mismatch;
    assign w_lockup   = (w_step_state == LOCKUP_MASK[ORDER-1:0]);
    assign w_bit_sum  = r_bit_cnt + BCW'(DW);

`ifdef LA_PRBS_CHECK_BITERR_EN
    assign w_inc = prbs_popcount(64'(w_mismatch));
`else
    assign w_inc = 7'd1;
`endif

    // Widened add so that a large per-word increment cannot wrap before clamping.
    assign w_err_sum = SW'(r_err_cnt) + SW'(w_inc);
    assign w_err_sat = (w_err_sum > SW'(CNT_MAX)) ? CNT_MAX : w_err_sum[CW-1:0];

    // Next-state, counter and output computation for one received word.
    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_good_nxt      = r_good_cnt;
        w_bad_nxt       = r_bad_cnt;
        w_locked_nxt    = r_locked;
        w_err_valid_nxt = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;

        if (!en) begin
            w_state_nxt   = ST_HUNT;
            w_locked_nxt  = 1'b0;
            w_bit_cnt_nxt = '0;
            w_good_nxt    = '0;
            w_bad_nxt     = '0;
        end else if (valid_in) begin
            w_lfsr_nxt = w_step_state;
            case (r_state)
                ST_HUNT: begin
                    // The word that fills the register is only used to seed it.
                    if (w_bit_sum >= BCW'(ORDER)) begin
                        w_state_nxt   = ST_CHECK;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = w_bit_sum;
                    end
                end
                ST_CHECK: begin
                    if (w_word_err) begin
                        w_good_nxt = '0;
                    end else if (r_good_cnt >= GCW'(LOCK_CNT - 1)) begin
                        w_state_nxt  = ST_LOCKED;
                        w_locked_nxt = 1'b1;
                        w_good_nxt   = '0;
                    end else begin
                        w_good_nxt = r_good_cnt + GCW'(1'b1);
                    end
                end
                ST_LOCKED: begin
                    if (!w_word_err) begin
                        w_bad_nxt = '0;
                    end else if (r_bad_cnt >= LCW'(LOSS_CNT - 1)) begin
                        w_state_nxt  = ST_HUNT;
                        w_locked_nxt = 1'b0;
                        w_bad_nxt    = '0;
                        w_good_nxt   = '0;
                    end else begin
                        w_bad_nxt = r_bad_cnt + LCW'(1'b1);
                    end
                end
                default: begin
                    w_state_nxt  = ST_HUNT;
                    w_locked_nxt = 1'b0;
                end
            endcase

            // Errors of the word are still reported even if it also hits lockup.
            if ((r_state != ST_HUNT) && w_word_err) begin
                w_err_valid_nxt = 1'b1;
                w_err_cnt_nxt   = w_err_sat;
            end else begin
                w_err_valid_nxt = 1'b0;
            end

            if (w_lockup) begin
                w_state_nxt   = ST_HUNT;
                w_lfsr_nxt    = '0;
                w_locked_nxt  = 1'b0;
                w_bit_cnt_nxt = '0;
                w_good_nxt    = '0;
                w_bad_nxt     = '0;
            end else begin
                w_lfsr_nxt = w_step_state;
            end
        end else begin
            w_err_valid_nxt = 1'b0;
        end

        if (clr_cnt) begin
            w_err_cnt_nxt = '0;
        end else begin
            w_err_cnt_nxt = w_err_cnt_nxt;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_lfsr      <= '0;
            r_bit_cnt   <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_good_cnt  <= w_good_nxt;
            r_bad_cnt   <= w_bad_nxt;
            r_locked    <= w_locked_nxt;
            r_err_valid <= w_err_valid_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_valid = r_err_valid;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_la_prbs_check.sv
// ---------------------------------------------------------------------------
// tb_la_prbs_check
// Two checker instances (CW=16 and CW=4) share one stimulus stream. A
// bit-history reference model predicts locked / err_valid / err_cnt for each
// cycle; directed checks cover lock timing, single-error response, loss of
// lock, enable, lockup, saturation, clear priority and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_la_prbs_check;

    localparam int ORDER = 7;
    localparam int TA    = 7;   // history distances of the two taps
    localparam int TB    = 6;
    localparam int LOCKN = 4;
    localparam int LOSSN = 4;
`ifdef LA_PRBS_CHECK_BITERR_EN
    localparam bit BITERR = 1'b1;
`else
    localparam bit BITERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       valid_in;
    logic [7:0] data_in;
    logic       clr_cnt;
    logic        locked_a, err_valid_a;
    logic [15:0] err_cnt_a;
    logic        locked_b, err_valid_b;
    logic [3:0]  err_cnt_b;

    always #5 clk = ~clk;

    la_prbs_check #(.PROP("DEFAULT"), .DW(8), .ORDER(7), .LOCK_CNT(4), .LOSS_CNT(4), .CW(16)) u_dut (
        .clk(clk), .reset(reset), .en(en), .valid_in(valid_in), .data_in(data_in),
        .clr_cnt(clr_cnt), .locked(locked_a), .err_valid(err_valid_a), .err_cnt(err_cnt_a));

    la_prbs_check #(.PROP("DEFAULT"), .DW(8), .ORDER(7), .LOCK_CNT(4), .LOSS_CNT(4), .CW(4)) u_dut_cw4 (
        .clk(clk), .reset(reset), .en(en), .valid_in(valid_in), .data_in(data_in),
        .clr_cnt(clr_cnt), .locked(locked_b), .err_valid(err_valid_b), .err_cnt(err_cnt_b));

    int checks   = 0;
    int failures = 0;

    // Reference model: hist[k] = bit received k+1 bits ago.
    bit m_hist[$];
    bit g_hist[$];
    int m_mode;      // 0 hunting, 1 checking, 2 locked
    int m_seen, m_good, m_bad;
    bit m_locked, m_ev;
    int m_cnt_a, m_cnt_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void zero_hist();
        m_hist = {};
        for (int k = 0; k < ORDER; k++) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        zero_hist();
        m_mode = 0; m_seen = 0; m_good = 0; m_bad = 0;
        m_locked = 1'b0; m_ev = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    endfunction

    // Clean PRBS7 generator seeded with zero.
    function automatic logic [7:0] gen_word();
        logic [7:0] w;
        bit b;
        for (int i = 0; i < 8; i++) begin
            b = ~(g_hist[TA-1] ^ g_hist[TB-1]);
            g_hist.push_front(b);
            void'(g_hist.pop_back());
            w[i] = b;
        end
        return w;
    endfunction

    function automatic void model_step(input bit e, input bit v, input logic [7:0] d, input bit c);
        int  nerr, inc;
        bit  p, checking, all1;
        m_ev = 1'b0;
        if (!e) begin
            m_mode = 0; m_locked = 1'b0; m_seen = 0; m_good = 0; m_bad = 0;
        end else if (v) begin
            nerr = 0;
            for (int i = 0; i < 8; i++) begin
                p = ~(m_hist[TA-1] ^ m_hist[TB-1]);
                if (d[i] != p) nerr++;
                m_hist.push_front(d[i]);
                void'(m_hist.pop_back());
            end
            checking = (m_mode != 0);
            if (m_mode == 0) begin
                m_seen += 8;
                if (m_seen >= ORDER) begin m_mode = 1; m_seen = 0; end
            end else if (m_mode == 1) begin
                if (nerr > 0) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == LOCKN) begin m_mode = 2; m_locked = 1'b1; m_good = 0; end
                end
            end else begin
                if (nerr == 0) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == LOSSN) begin m_mode = 0; m_locked = 1'b0; m_bad = 0; m_good = 0; end
                end
            end
            all1 = 1'b1;
            foreach (m_hist[k]) if (!m_hist[k]) all1 = 1'b0;
            if (all1) begin
                zero_hist();
                m_mode = 0; m_locked = 1'b0; m_seen = 0; m_good = 0; m_bad = 0;
            end
            if (checking && nerr > 0) begin
                m_ev = 1'b1;
                inc = BITERR ? nerr : 1;
                m_cnt_a = (m_cnt_a + inc > 65535) ? 65535 : m_cnt_a + inc;
                m_cnt_b = (m_cnt_b + inc > 15) ? 15 : m_cnt_b + inc;
            end
        end
        if (c) begin m_cnt_a = 0; m_cnt_b = 0; end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_locked"},    64'(locked_a),    64'(m_locked));
        chk({tag, "_errv"},      64'(err_valid_a), 64'(m_ev));
        chk({tag, "_errcnt"},    64'(err_cnt_a),   64'(m_cnt_a));
        chk({tag, "_locked4"},   64'(locked_b),    64'(m_locked));
        chk({tag, "_errv4"},     64'(err_valid_b), 64'(m_ev));
        chk({tag, "_errcnt4"},   64'(err_cnt_b),   64'(m_cnt_b));
    endtask

    task automatic step(input bit e, input bit v, input logic [7:0] d, input bit c, input string tag);
        en = e; valid_in = v; data_in = d; clr_cnt = c;
        model_step(e, v, d, c);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic relock_with_bubbles(input string tag);
        int nv = 0;
        int guard = 0;
        while (nv < 5 && guard < 200) begin
            guard++;
            if ($urandom_range(3) == 0) step(1'b1, 1'b0, 8'($urandom), 1'b0, tag);
            else begin
                step(1'b1, 1'b1, gen_word(), 1'b0, tag);
                nv++;
                if (nv == 4) chk({tag, "_not_yet"}, 64'(locked_a), 64'd0);
            end
        end
        chk({tag, "_locked5"}, 64'(locked_a), 64'd1);
    endtask

    initial begin
        logic [7:0] d;
        int nv, guard, held;
        bit done;

        reset = 1'b1; en = 1'b0; valid_in = 1'b0; data_in = 8'h00; clr_cnt = 1'b0;
        g_hist = {};
        for (int k = 0; k < ORDER; k++) g_hist.push_back(1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_locked", 64'(locked_a), 64'd0);
        reset = 1'b0;

        // Clean lock: one hunting word then four good words.
        for (int w = 1; w <= 5; w++) begin
            step(1'b1, 1'b1, gen_word(), 1'b0, "lock");
            if (w == 4) chk("lock_w4", 64'(locked_a), 64'd0);
        end
        chk("lock_w5", 64'(locked_a), 64'd1);
        chk("lock_w5_b", 64'(locked_b), 64'd1);

        // Clean stream with bubbles up to 1000 valid words.
        nv = 5; guard = 0;
        while (nv < 1000 && guard < 5000) begin
            guard++;
            if ($urandom_range(3) == 0) step(1'b1, 1'b0, 8'($urandom), 1'b0, "clean");
            else begin step(1'b1, 1'b1, gen_word(), 1'b0, "clean"); nv++; end
        end
        chk("clean_errcnt", 64'(err_cnt_a), 64'd0);
        chk("clean_locked", 64'(locked_a), 64'd1);

        // Single flipped bit: three mismatches spread over two words.
        d = gen_word();
        d[3] = ~d[3];
        step(1'b1, 1'b1, d, 1'b0, "flip");
        chk("flip_errv", 64'(err_valid_a), 64'd1);
        repeat (10) step(1'b1, 1'b1, gen_word(), 1'b0, "postflip");
        chk("single_errcnt", 64'(err_cnt_a), BITERR ? 64'd3 : 64'd2);
        chk("single_locked", 64'(locked_a), 64'd1);

        step(1'b1, 1'b0, 8'h00, 1'b1, "clr");
        chk("clr_zero", 64'(err_cnt_a), 64'd0);

        // Loss of lock on a constant pattern.
        for (int w = 1; w <= 4; w++) begin
            step(1'b1, 1'b1, 8'hA5, 1'b0, "loss");
            if (w == 3) chk("loss_w3", 64'(locked_a), 64'd1);
        end
        chk("loss_w4", 64'(locked_a), 64'd0);
        if (!BITERR) chk("loss_errcnt", 64'(err_cnt_a), 64'd4);
        held = m_cnt_a;
        step(1'b1, 1'b1, 8'hA5, 1'b0, "hunt_nocount");
        chk("hunt_nocount", 64'(err_cnt_a), 64'(held));

        // Enable drop, relock with bubbles; then drop enable while locked.
        step(1'b0, 1'b1, gen_word(), 1'b0, "en_off1");
        relock_with_bubbles("relock1");
        held = m_cnt_a;
        step(1'b0, 1'b0, 8'h00, 1'b0, "en_off2");
        chk("en_off_locked", 64'(locked_a), 64'd0);
        chk("en_off_held", 64'(err_cnt_a), 64'(held));
        relock_with_bubbles("relock2");

        // Lockup: all-ones words while hunting.
        held = m_cnt_a;
        step(1'b0, 1'b0, 8'h00, 1'b0, "to_hunt");
        step(1'b1, 1'b1, 8'hFF, 1'b0, "lockup1");
        step(1'b1, 1'b1, 8'hFF, 1'b0, "lockup2");
        chk("lockup_locked", 64'(locked_a), 64'd0);
        chk("lockup_errv", 64'(err_valid_a), 64'd0);
        chk("lockup_cnt", 64'(err_cnt_a), 64'(held));

        // Random data: the CW=4 counter saturates.
        repeat (150) step(1'b1, 1'($urandom_range(1)) | 1'b1, 8'($urandom), 1'b0, "rand");
        chk("sat_cw4", 64'(err_cnt_b), 64'd15);

        // Clear together with an errored word: clear wins.
        done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            step(1'b1, 1'b1, 8'($urandom), 1'b1, "clr_err");
            if (m_ev) begin
                chk("clr_wins", 64'(err_cnt_a), 64'd0);
                chk("clr_wins4", 64'(err_cnt_b), 64'd0);
                done = 1'b1;
            end
        end
        chk("clr_err_found", 64'(done), 64'd1);

        // Reset mid-stream.
        repeat (20) step(1'b1, 1'b1, 8'($urandom), 1'b0, "pre_rst");
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all("midreset");
        reset = 1'b0;
        step(1'b1, 1'b1, gen_word(), 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
